vector_load_sequencer: RTL and testbench

VECTOR_LOAD_SEQUENCER -- requirements
Module: vector_load_sequencer

---
 rtl/vector_pkg.sv | 21 ++
 rtl/vector_load_sequencer.sv | 126 ++++++++++++
 tb/tb_vector_load_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/vector_pkg.sv
// Shared definitions for the vector load sequencer.
// Holds the vector geometry, the register-file shape, the index of the
// PC-shadowed register and the sequencer state encoding.
package vector_pkg;

    localparam int LANES     = 8;
    localparam int LANE_W    = 32;
    localparam int VREG_W    = 256;
    localparam int NUM_VREGS = 8;

    // Reads of register 7 return the PC, so a load into it would be invisible.
    localparam logic [2:0] VREG_PC = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_WB   = 2'd3
    } state_t;

endpackage

// File: rtl/vector_load_sequencer.sv
// Vector load sequencer: fetches LANES consecutive words from memory, one
// request outstanding at a time, assembles them into one vector and writes
// the vector to the register file in a single registered write cycle.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   start, base_addr, dst   load request: byte address of lane 0, target vreg
//   busy                    load in progress (through the write-back cycle)
//   mem_req, mem_addr       read request and its address (base + 4*lane)
//   mem_gnt                 request accepted this cycle
//   mem_rvalid, mem_rdata   read data return
//   we3, wa3, wd3           registered register-file write port
//   done                    one-cycle pulse alongside we3
//   err                     one-cycle pulse when a load into the PC register is refused
//
// state  | meaning
// IDLE   | waiting for start
// REQ    | mem_req high for lane idx until granted
// WAIT   | waiting for read data of lane idx
// WB     | vector complete; write-back registered at the end of this cycle
module vector_load_sequencer #(
    parameter int LANES  = vector_pkg::LANES,
    parameter int LANE_W = vector_pkg::LANE_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [31:0]             base_addr,
    input  logic [2:0]              dst,
    output logic                    busy,
    output logic                    mem_req,
    output logic [31:0]             mem_addr,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [LANE_W-1:0]       mem_rdata,
    output logic                    we3,
    output logic [2:0]              wa3,
    output logic [LANES*LANE_W-1:0] wd3,
    output logic                    done,
    output logic                    err
);

    import vector_pkg::*;

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LANES - 1);

    state_t                    state;
    state_t                    state_nx;
    logic [31:0]               base_q;
    logic [2:0]                dst_q;
    logic [IDX_W-1:0]          idx;
    logic [LANES*LANE_W-1:0]   lanes;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start && dst != VREG_PC) state_nx = S_REQ;
            S_REQ:  if (mem_gnt) state_nx = S_WAIT;
            S_WAIT: if (mem_rvalid) state_nx = (idx == IDX_LAST) ? S_WB : S_REQ;
            S_WB:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Address is a pure function of latched registers, so it cannot move
    // while a request waits for its grant. Both are zero after reset.
    assign mem_req  = (state == S_REQ);
    assign mem_addr = base_q + (32'(idx) << 2);

    always_ff @(posedge clk) begin
        if (reset) begin
            base_q <= '0;
            dst_q  <= '0;
            idx    <= '0;
            lanes  <= '0;
            busy   <= 1'b0;
            we3    <= 1'b0;
            wa3    <= '0;
            wd3    <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            we3  <= 1'b0;
            done <= 1'b0;
            err  <= 1'b0;
            // Stays high through the cycle in which we3 is presented.
            busy <= (state_nx != S_IDLE) || (state == S_WB);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (dst == VREG_PC) begin
                            err <= 1'b1;
                        end else begin
                            base_q <= base_addr;
                            dst_q  <= dst;
                            idx    <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        lanes[idx*LANE_W +: LANE_W] <= mem_rdata;
                        if (idx != IDX_LAST) idx <= idx + 1'b1;
                    end
                end
                S_WB: begin
                    we3  <= 1'b1;
                    done <= 1'b1;
                    wa3  <= dst_q;
                    wd3  <= lanes;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_load_sequencer.sv
// Self-checking bench for vector_load_sequencer. The bench plays the memory,
// choosing grant/data delays at random, and predicts addresses and the
// written vector from the load rules (address = base + 4*lane, lane i of the
// vector = i-th returned word, write-back 17 cycles after start when memory
// never stalls).
module tb_vector_load_sequencer;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [31:0]  base_addr;
    logic [2:0]   dst;
    logic         busy;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_gnt;
    logic         mem_rvalid;
    logic [31:0]  mem_rdata;
    logic         we3;
    logic [2:0]   wa3;
    logic [255:0] wd3;
    logic         done;
    logic         err;

    int passed = 0;
    int total  = 0;

    vector_load_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .dst(dst),
        .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .we3(we3), .wa3(wa3),
        .wd3(wd3), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // One full load. pattern selects 0x11111111*(i+1) data instead of random.
    task automatic do_load(input logic [31:0] base, input logic [2:0] d, input int max_dly,
                           input bit pattern, input bit stall4, input bit extra_start,
                           input bit check_lat);
        logic [31:0]  data [8];
        logic [255:0] exp_vec;
        logic [31:0]  exp_addr;
        int cyc, gd, rd, lat, pulses;
        for (int i = 0; i < 8; i++) begin
            data[i] = pattern ? 32'h11111111 * 32'(i + 1) : $urandom;
            exp_vec[i*32 +: 32] = data[i];
        end
        @(negedge clk);
        start = 1'b1; base_addr = base; dst = d;
        @(posedge clk);
        cyc = 0;
        @(negedge clk);
        start = 1'b0; base_addr = $urandom; dst = 3'($urandom_range(0, 6));
        total++;
        if (busy !== 1'b1) $display("FAIL busy_after_start: got %b want 1", busy); else passed++;
        for (int i = 0; i < 8; i++) begin
            exp_addr = base + 32'(i) * 32'd4;
            gd = (stall4 && i == 4) ? 3 : $urandom_range(0, max_dly);
            for (int k = 0; k <= gd; k++) begin
                total++;
                if (mem_req !== 1'b1 || mem_addr !== exp_addr)
                    $display("FAIL req lane %0d: got req=%b addr=%h want req=1 addr=%h", i, mem_req, mem_addr, exp_addr);
                else passed++;
                if (extra_start && i == 4 && k == 0) begin
                    start = 1'b1; dst = 3'd3; base_addr = 32'h0000_5000;
                end
                mem_gnt = (k == gd);
                @(posedge clk); cyc++;
                @(negedge clk);
                mem_gnt = 1'b0; start = 1'b0;
            end
            rd = $urandom_range(0, max_dly);
            for (int k = 0; k <= rd; k++) begin
                total++;
                if (mem_req !== 1'b0) $display("FAIL req_low_in_wait lane %0d: got %b want 0", i, mem_req);
                else passed++;
                mem_rvalid = (k == rd);
                mem_rdata  = (k == rd) ? data[i] : $urandom;
                @(posedge clk); cyc++;
                @(negedge clk);
                mem_rvalid = 1'b0;
            end
        end
        lat = -1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            if (we3 === 1'b1) begin
                lat = cyc;
                break;
            end
        end
        total++;
        if (lat < 0) $display("FAIL we3_timeout: got no we3 want one within 6 cycles");
        else passed++;
        if (check_lat) begin
            total++;
            if (lat != 17) $display("FAIL latency: got %0d want 17", lat); else passed++;
        end
        total++;
        if (wa3 !== d || done !== 1'b1 || busy !== 1'b1)
            $display("FAIL wb_ctrl: got wa3=%0d done=%b busy=%b want wa3=%0d done=1 busy=1", wa3, done, busy, d);
        else passed++;
        total++;
        if (wd3 !== exp_vec) $display("FAIL wd3: got %h want %h", wd3, exp_vec); else passed++;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (we3 !== 1'b0 || done !== 1'b0) pulses++;
        end
        total++;
        if (pulses != 0) $display("FAIL single_pulse: got %0d extra we3/done cycles want 0", pulses); else passed++;
        total++;
        if (wa3 !== d || wd3 !== exp_vec || busy !== 1'b0)
            $display("FAIL hold_after_wb: got wa3=%0d busy=%b wd3=%h want wa3=%0d busy=0 wd3=%h", wa3, busy, wd3, d, exp_vec);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; base_addr = '0; dst = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, mem_req, we3, done, err} !== 5'b0 || mem_addr !== 32'h0 || wa3 !== 3'h0 || wd3 !== 256'h0)
            $display("FAIL reset_state: got busy=%b req=%b we3=%b done=%b err=%b addr=%h wa3=%0d wd3=%h want all 0",
                     busy, mem_req, we3, done, err, mem_addr, wa3, wd3);
        else passed++;
    endtask

    task automatic test_basic();
        do_load(32'h0000_0100, 3'd2, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_err();
        int bad;
        @(negedge clk);
        start = 1'b1; dst = 3'd7; base_addr = 32'h0000_2000;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        total++;
        if (err !== 1'b1) $display("FAIL err_pulse: got %b want 1", err); else passed++;
        bad = 0;
        for (int k = 0; k < 6; k++) begin
            if (mem_req !== 1'b0 || we3 !== 1'b0 || busy !== 1'b0) bad++;
            @(posedge clk);
            @(negedge clk);
            if (err !== 1'b0) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL err_side_effects: got %0d bad cycles want 0", bad); else passed++;
    endtask

    task automatic test_wrap();
        do_load(32'hFFFF_FFF8, 3'd5, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_stall();
        do_load(32'h0000_4000, 3'd1, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_abort();
        int bad;
        @(negedge clk);
        start = 1'b1; base_addr = 32'h0000_3000; dst = 3'd4;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_gnt = 1'b1;
            @(posedge clk); @(negedge clk);
            mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = $urandom;
            @(posedge clk); @(negedge clk);
            mem_rvalid = 1'b0;
        end
        total++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h0000_3014)
            $display("FAIL lane5_req: got req=%b addr=%h want req=1 addr=00003014", mem_req, mem_addr);
        else passed++;
        mem_gnt = 1'b1;
        @(posedge clk); @(negedge clk);
        mem_gnt = 1'b0;
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = $urandom;
        @(posedge clk); @(negedge clk);
        mem_rvalid = 1'b0;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            if ({busy, mem_req, we3, done, err} !== 5'b0 || mem_addr !== 32'h0 || wa3 !== 3'h0 || wd3 !== 256'h0)
                bad++;
            @(posedge clk); @(negedge clk);
        end
        total++;
        if (bad != 0) $display("FAIL abort_outputs: got %0d nonzero cycles want 0", bad); else passed++;
        do_load(32'h0000_3000, 3'd4, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++)
            do_load($urandom, 3'($urandom_range(0, 6)), 3, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_load(32'h0000_8000, 3'd0, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        do_load(32'h0000_8020, 3'd6, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_err();
        test_wrap();
        test_stall();
        test_reset_abort();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
